// File: rtl/tile_gfx_pkg.sv
// Shared definitions for the tile graphics pixel path.
// Holds tile geometry, pipeline latency, the packed RGB pixel type and
// the palette reset ramp used by palette_rf.
package tile_gfx_pkg;

    localparam int unsigned TILE_LOG2 = 5;
    localparam int unsigned TILE_SIZE = 1 << TILE_LOG2;
    localparam int unsigned PIPE_LAT  = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Grey ramp: entry i = {3{8'h11*i}}, so 0 is black and 15 is white.
    function automatic rgb_t pal_default(input int unsigned i);
        logic [7:0] lvl;
        lvl = 8'(i * 32'h11);
        return '{r: lvl, g: lvl, b: lvl};
    endfunction

endpackage

// File: rtl/palette_rf.sv
// Colour palette register file: 2^CIDX_BITS entries of 24-bit RGB.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset (restores grey ramp)
//   wr_en              - write strobe (already qualified by the handshake)
//   wr_idx, wr_rgb     - write entry and value
//   rd_idx             - combinational read index
//   rd_rgb             - read value; a same-cycle write is not visible until next cycle
module palette_rf
    import tile_gfx_pkg::*;
#(
    parameter int unsigned CIDX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [CIDX_BITS-1:0] wr_idx,
    input  logic [23:0]          wr_rgb,
    input  logic [CIDX_BITS-1:0] rd_idx,
    output logic [23:0]          rd_rgb
);

    localparam int unsigned Entries = 1 << CIDX_BITS;

    rgb_t mem_q [Entries];
    rgb_t mem_d [Entries];

    always_comb begin
        for (int unsigned i = 0; i < Entries; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[wr_idx] = wr_rgb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                mem_q[i] <= pal_default(i);
            end
        end else begin
            for (int unsigned i = 0; i < Entries; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read from the registered contents so a write lands one cycle later.
    assign rd_rgb = mem_q[rd_idx];

endmodule

// File: rtl/tile_pixel_gen.sv
// Tile pixel generator: tile index + in-tile coordinates -> 24-bit RGB pixel.
// Three-stage pipeline with the external synchronous ROM forming stage 2:
//   S1: rom_addr and sync registered
//   S2: ROM returns rom_data (its own register); sync advanced alongside
//   S3: palette lookup of rom_data, blanked when not active; sync to outputs
// Ports:
//   clk, rst_n                  - pixel clock, asynchronous active-low reset
//   tile_idx, x_low, y_low      - current pixel's tile number and coordinates
//   vs_in, hs_in, de_in         - timing qualifying the current pixel
//   rom_addr / rom_data         - tile bitmap ROM, data valid one cycle after address
//   pal_wr_valid/ready/idx/rgb  - palette write handshake, accepted only in blanking
//   pixel_data                  - {R,G,B} output
//   vs_out, hs_out, de_out      - timing aligned with pixel_data
module tile_pixel_gen
    import tile_gfx_pkg::*;
#(
    parameter int unsigned TILE_BITS = 4,
    parameter int unsigned CIDX_BITS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [TILE_BITS-1:0]             tile_idx,
    input  logic [TILE_LOG2-1:0]             x_low,
    input  logic [TILE_LOG2-1:0]             y_low,
    input  logic                             vs_in,
    input  logic                             hs_in,
    input  logic                             de_in,
    output logic [TILE_BITS+2*TILE_LOG2-1:0] rom_addr,
    input  logic [CIDX_BITS-1:0]             rom_data,
    input  logic                             pal_wr_valid,
    output logic                             pal_wr_ready,
    input  logic [CIDX_BITS-1:0]             pal_wr_idx,
    input  logic [23:0]                      pal_wr_rgb,
    output logic [23:0]                      pixel_data,
    output logic                             vs_out,
    output logic                             hs_out,
    output logic                             de_out
);

    localparam int unsigned AddrBits = TILE_BITS + 2 * TILE_LOG2;

    logic [AddrBits-1:0] rom_addr_q, rom_addr_d;
    logic                vs_s1_q, hs_s1_q, de_s1_q;
    logic                vs_s1_d, hs_s1_d, de_s1_d;
    logic                vs_s2_q, hs_s2_q, de_s2_q;
    logic                vs_s2_d, hs_s2_d, de_s2_d;
    logic                vs_out_q, hs_out_q, de_out_q;
    logic                vs_out_d, hs_out_d, de_out_d;
    rgb_t                pixel_q, pixel_d;
    logic [23:0]         pal_rd;
    logic                pal_wr_en;

    // Any active pixel anywhere in the pipe blocks writes, so a line never
    // sees the palette change part way through.
    assign pal_wr_ready = !(de_in | de_s1_q | de_s2_q | de_out_q);
    assign pal_wr_en    = pal_wr_valid & pal_wr_ready;

    palette_rf #(
        .CIDX_BITS (CIDX_BITS)
    ) u_palette_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (pal_wr_en),
        .wr_idx (pal_wr_idx),
        .wr_rgb (pal_wr_rgb),
        .rd_idx (rom_data),
        .rd_rgb (pal_rd)
    );

    always_comb begin
        rom_addr_d = {tile_idx, y_low, x_low};
        vs_s1_d    = vs_in;
        hs_s1_d    = hs_in;
        de_s1_d    = de_in;
        vs_s2_d    = vs_s1_q;
        hs_s2_d    = hs_s1_q;
        de_s2_d    = de_s1_q;
        vs_out_d   = vs_s2_q;
        hs_out_d   = hs_s2_q;
        de_out_d   = de_s2_q;
        pixel_d    = de_s2_q ? rgb_t'(pal_rd) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            vs_s1_q    <= 1'b0;
            hs_s1_q    <= 1'b0;
            de_s1_q    <= 1'b0;
            vs_s2_q    <= 1'b0;
            hs_s2_q    <= 1'b0;
            de_s2_q    <= 1'b0;
            vs_out_q   <= 1'b0;
            hs_out_q   <= 1'b0;
            de_out_q   <= 1'b0;
            pixel_q    <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            vs_s1_q    <= vs_s1_d;
            hs_s1_q    <= hs_s1_d;
            de_s1_q    <= de_s1_d;
            vs_s2_q    <= vs_s2_d;
            hs_s2_q    <= hs_s2_d;
            de_s2_q    <= de_s2_d;
            vs_out_q   <= vs_out_d;
            hs_out_q   <= hs_out_d;
            de_out_q   <= de_out_d;
            pixel_q    <= pixel_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pixel_data = pixel_q;
    assign vs_out     = vs_out_q;
    assign hs_out     = hs_out_q;
    assign de_out     = de_out_q;

endmodule

// File: tb/tb_tile_pixel_gen.sv
// Self-checking bench for tile_pixel_gen with a behavioural ROM and a
// cycle-history reference model (inputs delayed by three cycles, palette
// as a plain array updated on accepted writes).
module tb_tile_pixel_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  tile_idx = '0;
    logic [4:0]  x_low = '0;
    logic [4:0]  y_low = '0;
    logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    logic [13:0] rom_addr;
    logic [3:0]  rom_data = '0;
    logic        pal_wr_valid = 1'b0;
    logic        pal_wr_ready;
    logic [3:0]  pal_wr_idx = '0;
    logic [23:0] pal_wr_rgb = '0;
    logic [23:0] pixel_data;
    logic        vs_out, hs_out, de_out;

    always #5 clk = ~clk;

    tile_pixel_gen #(
        .TILE_BITS (4),
        .CIDX_BITS (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tile_idx     (tile_idx),
        .x_low        (x_low),
        .y_low        (y_low),
        .vs_in        (vs_in),
        .hs_in        (hs_in),
        .de_in        (de_in),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .pal_wr_valid (pal_wr_valid),
        .pal_wr_ready (pal_wr_ready),
        .pal_wr_idx   (pal_wr_idx),
        .pal_wr_rgb   (pal_wr_rgb),
        .pixel_data   (pixel_data),
        .vs_out       (vs_out),
        .hs_out       (hs_out),
        .de_out       (de_out)
    );

    // Tile ROM: random contents, optionally overridden with a constant index.
    logic [3:0] rom_mem [16384];
    logic       rom_force_en = 1'b0;
    logic [3:0] rom_force_val = '0;

    function automatic logic [3:0] rom_val(input logic [13:0] a);
        return rom_force_en ? rom_force_val : rom_mem[a];
    endfunction

    always @(posedge clk) rom_data <= rom_val(rom_addr);

    // Reference model state
    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [13:0] addr;
    } in_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [23:0] rgb;
    } wr_t;

    logic [23:0] pal_m [16];
    in_t         h0, h1, h2;
    wr_t         wq [$];
    int          acc_log [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            pal_m[i] = {3{8'(i * 17)}};
        end
        h0 = '0;
        h1 = '0;
        h2 = '0;
    endtask

    // One clock: check ready, advance model, cross the edge, check outputs.
    task automatic tick();
        in_t         cur;
        logic        rdy_m, acc;
        logic [23:0] e_pix;
        in_t         e_in;
        wr_t         w;
        if (!pal_wr_valid && wq.size() > 0) begin
            w            = wq.pop_front();
            pal_wr_idx   = w.idx;
            pal_wr_rgb   = w.rgb;
            pal_wr_valid = 1'b1;
        end
        #1;
        cur   = '{vs: vs_in, hs: hs_in, de: de_in, addr: {tile_idx, y_low, x_low}};
        rdy_m = !(cur.de | h0.de | h1.de | h2.de);
        chk("ready", 32'(pal_wr_ready), 32'(rdy_m));
        e_in  = h1;
        e_pix = h1.de ? pal_m[rom_val(h1.addr)] : 24'h0;
        acc   = pal_wr_valid && rdy_m;
        if (acc) begin
            pal_m[pal_wr_idx] = pal_wr_rgb;
            acc_log.push_back(cyc);
        end
        h2 = h1;
        h1 = h0;
        h0 = cur;
        @(posedge clk);
        #1;
        chk("rom_addr", 32'(rom_addr), 32'(cur.addr));
        chk("vs_out", 32'(vs_out), 32'(e_in.vs));
        chk("hs_out", 32'(hs_out), 32'(e_in.hs));
        chk("de_out", 32'(de_out), 32'(e_in.de));
        chk("pixel", 32'(pixel_data), 32'(e_pix));
        cyc++;
        if (acc) begin
            if (wq.size() > 0) begin
                w          = wq.pop_front();
                pal_wr_idx = w.idx;
                pal_wr_rgb = w.rgb;
            end else begin
                pal_wr_valid = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic vs, input logic hs, input logic de,
                         input logic [3:0] t, input logic [4:0] x, input logic [4:0] y);
        vs_in    = vs;
        hs_in    = hs;
        de_in    = de;
        tile_idx = t;
        x_low    = x;
        y_low    = y;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 5'h0);
    endtask

    // Short active line with a fixed colour index; checks every pixel that
    // leaves the pipe against a directly stated colour.
    task automatic const_line(input logic [3:0] cidx, input int len, input logic [23:0] rgb,
                              input string tag);
        rom_force_en  = 1'b1;
        rom_force_val = cidx;
        for (int i = 0; i < len + 3; i++) begin
            drive(1'b0, 1'b1, i < len, 4'($urandom), 5'($urandom), 5'($urandom));
            if (i >= 2 && i < len + 2) chk(tag, 32'(pixel_data), 32'(rgb));
        end
        idle(2);
        rom_force_en = 1'b0;
    endtask

    initial begin
        int last_act;
        int run;
        logic act;

        for (int i = 0; i < 16384; i++) rom_mem[i] = 4'($urandom);
        model_reset();

        // Reset state
        rst_n = 1'b0;
        #3;
        chk("rst_pixel", 32'(pixel_data), 32'h0);
        chk("rst_addr", 32'(rom_addr), 32'h0);
        chk("rst_de", 32'(de_out), 32'h0);
        chk("rst_ready", 32'(pal_wr_ready), 32'h1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(4);

        // Address formation
        drive(1'b0, 1'b0, 1'b1, 4'd2, 5'd3, 5'd1);
        chk("addr_0823", 32'(rom_addr), 32'h0823);
        idle(4);

        // Long line, constant cidx 5, toggling sync
        rom_force_en  = 1'b1;
        rom_force_val = 4'd5;
        for (int i = 0; i < 1030; i++) begin
            drive(((i / 200) % 2) == 1, ((i / 37) % 2) == 1, i < 1024,
                  4'($urandom), 5'($urandom), 5'($urandom));
            if (i >= 2 && i < 1026) chk("grey5", 32'(pixel_data), 32'h555555);
        end
        idle(3);
        rom_force_en = 1'b0;

        // Back-to-back writes in blanking
        acc_log.delete();
        wq.push_back('{idx: 4'd7, rgb: 24'hFF0000});
        wq.push_back('{idx: 4'd8, rgb: 24'h00FF00});
        idle(4);
        chk("b2b_count", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() == 2) chk("b2b_consec", 32'(acc_log[1] - acc_log[0]), 32'd1);
        const_line(4'd7, 8, 24'hFF0000, "red7");
        const_line(4'd8, 4, 24'h00FF00, "green8");

        // Write held across an active line
        acc_log.delete();
        rom_force_en  = 1'b1;
        rom_force_val = 4'd9;
        wq.push_back('{idx: 4'd9, rgb: 24'h0000FF});
        last_act = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 19) last_act = cyc;
            drive(1'b0, 1'b1, 1'b1, 4'($urandom), 5'($urandom), 5'($urandom));
            if (i >= 2) chk("old9", 32'(pixel_data), 32'h999999);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 5'h0);
            if (i < 2) chk("old9_tail", 32'(pixel_data), 32'h999999);
        end
        rom_force_en = 1'b0;
        chk("held_count", 32'(acc_log.size()), 32'd1);
        if (acc_log.size() == 1) chk("held_cycle", 32'(acc_log[0]), 32'(last_act + 4));
        const_line(4'd9, 3, 24'h0000FF, "blue9");

        // Boundaries
        const_line(4'd0, 3, 24'h000000, "cidx0");
        const_line(4'd15, 3, 24'hFFFFFF, "cidx15");
        drive(1'b0, 1'b0, 1'b1, 4'd15, 5'd31, 5'd31);
        chk("addr_3fff", 32'(rom_addr), 32'h3FFF);
        idle(4);

        // Randomised traffic with random ROM contents and writes
        run = 0;
        act = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                act = !act;
                run = act ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 12));
            end
            run--;
            if (wq.size() == 0 && !pal_wr_valid && $urandom_range(0, 5) == 0)
                wq.push_back('{idx: 4'($urandom), rgb: 24'($urandom)});
            drive(1'($urandom), 1'($urandom), act, 4'($urandom), 5'($urandom), 5'($urandom));
        end
        idle(12);
        wq.delete();

        // Reset in the middle of an active line
        acc_log.delete();
        wq.push_back('{idx: 4'd7, rgb: 24'h123456});
        idle(3);
        chk("pre_rst_wr", 32'(acc_log.size()), 32'd1);
        rom_force_en  = 1'b1;
        rom_force_val = 4'd7;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, 4'($urandom), 5'($urandom), 5'($urandom));
            if (i >= 2) chk("new7", 32'(pixel_data), 32'h123456);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pixel", 32'(pixel_data), 32'h0);
        chk("mid_rst_de", 32'(de_out), 32'h0);
        chk("mid_rst_vs", 32'(vs_out), 32'h0);
        chk("mid_rst_hs", 32'(hs_out), 32'h0);
        chk("mid_rst_addr", 32'(rom_addr), 32'h0);
        model_reset();
        pal_wr_valid = 1'b0;
        vs_in = 1'b0;
        hs_in = 1'b0;
        de_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);
        const_line(4'd7, 5, 24'h777777, "revert7");
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_pixel_gen.md
# tile_pixel_gen

Pixel-generation stage that sits between the HDMI tile controller and the HDMI output: it turns the per-pixel tile index and in-tile coordinates into a 24-bit RGB pixel. It reads a synchronous tile-bitmap ROM, maps the 4-bit colour index through a CPU-writable 16-entry palette, and delays vs/hs/de so that sync and pixel leave aligned. The result drives `pixel_data` and the final sync outputs of the HDMI top.

## Interface
Parameters:
- `TILE_BITS`, 4, width of the tile index; sets ROM depth as `2^(TILE_BITS+10)`.
- `CIDX_BITS`, 4, colour-index width; the palette has `2^CIDX_BITS` entries.

Ports:
- `clk`, in, 1, pixel clock (148.5 MHz domain).
- `rst_n`, in, 1, asynchronous active-low reset.
- `tile_idx`, in, `TILE_BITS`, tile number from graphics RAM for the current pixel.
- `x_low`, in, 5, column within the 32×32 tile.
- `y_low`, in, 5, row within the 32×32 tile.
- `vs_in`, `hs_in`, `de_in`, in, 1 each, timing qualifying this cycle's `tile_idx`/`x_low`/`y_low`.
- `rom_addr`, out, `TILE_BITS+10`, tile ROM address, equal to `{tile_idx, y_low, x_low}`.
- `rom_data`, in, `CIDX_BITS`, ROM read data; valid one cycle after `rom_addr`.
- `pal_wr_valid`, in, 1, palette write request.
- `pal_wr_ready`, out, 1, palette write accept.
- `pal_wr_idx`, in, `CIDX_BITS`, palette entry to write.
- `pal_wr_rgb`, in, 24, palette entry value, {R,G,B}.
- `pixel_data`, out, 24, {R[23:16], G[15:8], B[7:0]}.
- `vs_out`, `hs_out`, `de_out`, out, 1 each, delayed timing aligned with `pixel_data`.

## Operation
- Stage S1 (registered): `rom_addr` and the S1 copies of vs/hs/de.
- Stage S2: `rom_data` is returned by the ROM. It is registered as `cidx_s2`, and vs/hs/de advance to S2.
- Stage S3 (registered):
  - `pixel_data` is `palette[cidx_s2]` when `de_s2`=1, otherwise 24'h000000.
  - vs/hs/de advance to the outputs.
- Palette: 16×24-bit register file.
  - Reset value of entry i is `{3{8'h11*i}}`, a grey ramp: entry 0 = 000000, entry 15 = FFFFFF.
- Write handshake:
  - `pal_wr_ready` = !(de_in | de_s1 | de_s2 | de_out), i.e. writes are accepted only in blanking, so the palette never changes mid-line.
  - A write occurs on a clock edge where valid && ready.
  - The valid-side master holds `pal_wr_idx`/`pal_wr_rgb` stable until accepted.
- A read of an entry in the same cycle it is written returns the old value; the new value is visible from the next cycle.
- No other state. The block does not inspect coordinates beyond forming the ROM address.

## Timing
- Latency is fixed at 3 clocks for every input: the `tile_idx`/`x_low`/`y_low`/vs/hs/de of cycle n appear as `pixel_data`/vs/hs/de_out at cycle n+3.
- `rom_addr` reflects cycle-n inputs at cycle n+1. `rom_data` is sampled at the edge ending cycle n+2.
- Reset values:
  - `rom_addr`=0, `pixel_data`=0, `vs_out`=`hs_out`=`de_out`=0.
  - All pipeline registers are 0 and the palette holds the grey ramp.
  - `pal_wr_ready`=1, because every de stage is 0.
- Reset asserted mid-frame: all outputs go to 0 immediately (asynchronously) and any palette writes are discarded. After release, the first valid output is 3 clocks after the first sampled input.
- Back-to-back writes: one per clock while ready=1.
- When de_in rises, ready falls combinationally in that same cycle; a write presented in that cycle is not accepted.
- After the last active pixel, ready returns 4 clocks after de_in falls.
- Polarity of vs/hs is passed through unchanged.

## Structure
- A shared package `tile_gfx_pkg` holds:
  - tile size 32 (`TILE_LOG2`=5);
  - `PIPE_LAT`=3;
  - the `rgb_t` 24-bit packing;
  - the palette reset function `pal_default(i)`.
- One sub-module, `palette_rf`: 16×24 register file with async reset, one write port and one combinational read port. Everything else stays in the top.

## Test plan
- Reset then idle: all outputs are 0 and `pal_wr_ready`=1. Drive de_in=1, tile 2, x=3, y=1 → `rom_addr`=14'h0823 one cycle later.
- Pipeline alignment: drive a de pulse of 1024 cycles with hs/vs toggling. Check `de_out`/`hs_out`/`vs_out` equal the inputs delayed by exactly 3. A ROM model returning cidx 5 gives `pixel_data`=555555 on every de_out cycle and 0 otherwise.
- Palette write in blanking: write idx 7=FF0000 and then, back-to-back, idx 8=00FF00. Both are accepted in consecutive cycles. A later active pixel with cidx 7 gives FF0000.
- Write blocked during active: hold valid during a line. ready stays 0 until 4 clocks after de_in falls, the write lands then, and no pixel of that line shows the new colour.
- Boundary indices: cidx 0 → 000000 and cidx 15 → FFFFFF after reset. A tile index of 15 with x=y=31 gives `rom_addr`=3FFF.
- Reset mid-line: assert rst_n=0 during active video → outputs are 0 that cycle. A previously written entry reverts to its grey default, e.g. entry 7 = 777777.
